uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports configurable data width, stop bits and optional parity. Each bit is sampled with a 3-sample majority vote at mid-bit, and start bits are validated so glitches are rejected. Received words leave through a ready/valid handshake with framing, parity and overrun status. It sits between the board RX pin and the packet/command layer.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 921600: line rate in bit/s. BPS_CNT = CLK_FREQ/BAUD (integer division, must be ≥ 8).
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- STOP_BITS, 1: 1 or 2; every stop bit is checked.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even. Only honoured when UART_RX_PARITY_EN is defined.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial line, idle high.
- out_data  out  DATA_BITS  received word, LSB = first bit on the line.
- out_valid  out  1  word available; held until accepted.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- frame_err  out  1  qualifies out_data; a stop bit sampled low.
- parity_err  out  1  qualifies out_data; parity mismatch.
- overrun  out  1  one-cycle pulse; a frame was dropped.

## Operation
- rx passes through a 2-FF synchroniser (reset value 1), then an edge register. A start is a falling edge on the synchronised line while in IDLE.
- Baud counter: 0..BPS_CNT-1. It clears on start detect and on every wrap. Width is $clog2(BPS_CNT).
- Majority sample: the synchronised rx is captured at counts M-1, M and M+1, where M = BPS_CNT/2. The bit value is the 2-of-3 majority, taken at count M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on falling edge.
  - START at sample: majority 1 → IDLE (false start, no output). Majority 0 → DATA.
  - DATA: shift in DATA_BITS bits, LSB first. Then → PARITY if parity is enabled, else → STOP.
  - PARITY: one bit. Error = XOR of data bits and parity bit ≠ (PARITY_MODE==1 ? 1 : 0).
  - STOP: sample STOP_BITS bits. Any 0 sets frame_err for this word. After the last stop sample → IDLE immediately, ready for the next start edge in the same bit time.
- Output register, loaded at the last stop sample:
  - If out_valid == 0, or out_valid && out_ready in that same cycle: load data and errors, set out_valid.
  - Else: keep the old word, drop the new one, pulse overrun.
- out_valid clears on the handshake cycle unless a new word loads in that same cycle.
- frame_err and parity_err change only on load.
- A break (rx low for a whole frame) yields one word with frame_err = 1. No new start is detected until rx returns high and falls again.
- Reset mid-frame: FSM → IDLE immediately. The partial frame is discarded and all outputs are cleared.

## Timing
- Reset values: out_data = 0, out_valid = 0, frame_err = 0, parity_err = 0, overrun = 0.
- Start detect is 3 sys_clk cycles after the rx falling edge (2 synchroniser stages plus the edge register).
- out_valid rises 1 cycle after the final stop-bit majority sample, about (1 + DATA_BITS + P + STOP_BITS − 0.5) bit times after the start edge, where P = 1 if parity is enabled, else 0.
- overrun is high for exactly one cycle per dropped word.
- out_ready has no combinational path to any output.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state and parity checker are built.
  - PARITY_MODE selects none, odd or even.
- UART_RX_PARITY_EN undefined:
  - No PARITY state, no parity logic.
  - PARITY_MODE is ignored.
  - parity_err is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - FSM state enum uart_rx_state_t;
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the BPS_CNT computation function, so it can be reused by a matching uart_tx_param.
- One sub-module, uart_rx_sampler: synchroniser, baud counter and 3-sample majority vote. It outputs bit_val and a one-cycle bit_strobe.
- The top level holds the FSM, shift register and output handshake.

## Test plan
- 8N1 at defaults (BPS_CNT = 54): send 0xA5 with out_ready = 1 → out_valid one cycle, out_data = 0xA5, both error flags 0.
- 0.5-bit low glitch on idle rx → no out_valid, FSM back in IDLE.
- With out_ready held 0, send 0x3C then 0xC3 → out_data stays 0x3C, one overrun pulse. Raise out_ready → 0x3C accepted, out_valid drops.
- Stop bit forced low on 0x55 → out_data = 0x55, frame_err = 1. With STOP_BITS = 2, second stop bit low → frame_err = 1.
- UART_RX_PARITY_EN with PARITY_MODE = 2, DATA_BITS = 7:
  - send 0x41 with correct parity bit 0 → parity_err = 0;
  - send with flipped parity bit → parity_err = 1.
- A single-cycle 0 spike at mid-bit of a 1 data bit → still read as 1. Assert sys_rst_n low mid-frame → all outputs 0, next clean frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity mode constants and
// the bit-period computation reused by the matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // System clocks per bit on the line (integer division).
  function automatic int calc_bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// UART RX front end: 2-FF synchroniser, edge register, bit-period counter
// and 3-sample majority vote around mid-bit. bit_strobe marks the cycle in
// which bit_val holds the voted value of the current bit.
module uart_rx_sampler #(
  parameter int BPS_CNT = 54
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rx,
  input  logic start,
  output logic rx_fall,
  output logic bit_val,
  output logic bit_strobe
);

  localparam int CW  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int MID = BPS_CNT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);

  logic          rx_p0;
  logic          rx_p1;
  logic          rx_p2;
  logic [CW-1:0] cnt;
  logic          smp0;
  logic          smp1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronise the line (idle-high reset) and keep one extra stage for edge detect.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Bit-period counter, realigned to every accepted start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (start || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge sys_clk) begin
    if (cnt == CNT_S0) smp0 <= rx_p1;
    if (cnt == CNT_S1) smp1 <= rx_p1;
  end

  assign rx_fall    = rx_p2 & ~rx_p1;
  assign bit_strobe = (cnt == CNT_S2);
  assign bit_val    = maj3(smp0, smp1, rx_p1);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data bits, stop bits and optional
// parity, majority-voted sampling and a ready/valid output with framing,
// parity and overrun status.
// Build option: define UART_RX_PARITY_EN to build the parity state/checker;
// without it PARITY_MODE has no effect and parity_err is tied low.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 921600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD);
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = (PARITY_MODE != PAR_NONE);
`else
  // Parity mode is accepted but has no effect in this build.
  localparam bit HAS_PAR = 1'b0 && (PARITY_MODE != PAR_NONE);
`endif
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  uart_rx_state_t       state;
  uart_rx_state_t       next_state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 rx_fall;
  logic                 bit_val;
  logic                 bit_strobe;
  logic                 start_det;
  logic                 shift_en;
  logic                 stop_en;
  logic                 frame_done;
  logic                 load;

  uart_rx_sampler #(
    .BPS_CNT(BPS_CNT)
  ) u_sampler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .start     (start_det),
    .rx_fall   (rx_fall),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= next_state;
  end

  // FSM next-state logic; all transitions happen on a bit sample except start.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (rx_fall) next_state = S_START;
      S_START:  if (bit_strobe) next_state = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (bit_strobe && bit_cnt == DATA_LAST)
                  next_state = HAS_PAR ? S_PARITY : S_STOP;
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (bit_strobe) next_state = S_STOP;
`endif
      S_STOP:   if (bit_strobe && bit_cnt == STOP_LAST) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic par_err_acc;
`endif

  // FSM outputs: per-state sample enables and end-of-frame marker.
  always_comb begin
    start_det  = (state == S_IDLE) && rx_fall;
    shift_en   = (state == S_DATA) && bit_strobe;
    stop_en    = (state == S_STOP) && bit_strobe;
    frame_done = stop_en && (bit_cnt == STOP_LAST);
`ifdef UART_RX_PARITY_EN
    par_en     = (state == S_PARITY) && bit_strobe;
`endif
  end

  // Bit index within the current state, restarted on every state change.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt <= '0;
    end else if (state != next_state) begin
      bit_cnt <= '0;
    end else if (shift_en || stop_en) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Payload shift register, LSB first on the line.
  always_ff @(posedge sys_clk) begin
    if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
  end

  // Remember any low stop bit seen before the final one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                ferr_acc <= 1'b0;
    else if (start_det)            ferr_acc <= 1'b0;
    else if (stop_en && !bit_val)  ferr_acc <= 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  // Parity check: data XOR parity bit must be 1 for odd, 0 for even.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     par_err_acc <= 1'b0;
    else if (start_det) par_err_acc <= 1'b0;
    else if (par_en)
      par_err_acc <= ((^shreg) ^ bit_val) != (PARITY_MODE == PAR_ODD);
  end
`endif

  // A finished word loads only if the output slot is free or being emptied now.
  assign load = frame_done && (!out_valid || out_ready);

  // Output word register with valid handshake and one-cycle overrun pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= frame_done && out_valid && !out_ready;
      if (load) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
        frame_err <= ferr_acc | ~bit_val;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity status travels with the word it qualifies.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) parity_err <= 1'b0;
    else if (load)  parity_err <= par_err_acc;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: a default 8N1 instance and a 7-bit,
// 2-stop-bit, even-parity instance (parity active with UART_RX_PARITY_EN).
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BPS = 50000000 / 921600;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx1 = 1'b1, rx2 = 1'b1;
  logic       ready1 = 1'b1, ready2 = 1'b1;
  logic [7:0] data1;
  logic [6:0] data2;
  logic       valid1, valid2, ferr1, ferr2, perr1, perr2, ovr1, ovr2;

  int tests = 0;
  int fails = 0;
  int vcnt1 = 0;
  int ocnt1 = 0;

  // {data[8:0], ferr, perr}
  typedef logic [10:0] word_t;
  word_t exp1[$], got1[$], exp2[$], got2[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[5];

  uart_rx_param dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_MODE(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx2),
    .out_data(data2), .out_valid(valid2), .out_ready(ready2),
    .frame_err(ferr2), .parity_err(perr2), .overrun(ovr2)
  );

  always #10 sys_clk = ~sys_clk;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (valid1) vcnt1++;
      if (ovr1) ocnt1++;
      if (valid1 && ready1) got1.push_back({1'b0, data1, ferr1, perr1});
      if (valid2 && ready2) got2.push_back({2'b00, data2, ferr2, perr2});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic set_rx(input int w, input logic v);
    if (w == 1) rx1 = v;
    else        rx2 = v;
  endtask

  task automatic hold_bit(input int w, input logic v, input bit spike);
    for (int i = 0; i < BPS; i++) begin
      set_rx(w, (spike && i == BPS / 2) ? ~v : v);
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int w, input int n);
    for (int i = 0; i < n; i++) hold_bit(w, 1'b1, 1'b0);
  endtask

  task automatic send(input int w, input logic [8:0] d, input int nbits,
                      input bit par_on, input logic par_bit,
                      input logic st1, input logic st2, input int nstop,
                      input int spike_bit);
    hold_bit(w, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(w, d[i], i == spike_bit);
    if (par_on) hold_bit(w, par_bit, 1'b0);
    hold_bit(w, st1, 1'b0);
    if (nstop == 2) hold_bit(w, st2, 1'b0);
    set_rx(w, 1'b1);
  endtask

  // Wait (bounded) for every expected word, then compare in order.
  task automatic drain(input int w, input int limit, input string nm);
    int n = 0;
    int missing, extra;
    if (w == 1) begin
      while (got1.size() < exp1.size() && n < limit) begin @(posedge sys_clk); n++; end
      while (exp1.size() > 0 && got1.size() > 0)
        chk(nm, 32'(got1.pop_front()), 32'(exp1.pop_front()));
      missing = exp1.size(); extra = got1.size();
      exp1.delete(); got1.delete();
    end else begin
      while (got2.size() < exp2.size() && n < limit) begin @(posedge sys_clk); n++; end
      while (exp2.size() > 0 && got2.size() > 0)
        chk(nm, 32'(got2.pop_front()), 32'(exp2.pop_front()));
      missing = exp2.size(); extra = got2.size();
      exp2.delete(); got2.delete();
    end
    #1;
    if (missing > 0) begin
      tests++; fails++;
      $display("FAIL %s timeout: got %0d words short, expected all words", nm, missing);
    end
    if (extra > 0) begin
      tests++; fails++;
      $display("FAIL %s extra: got %0d unexpected words, expected 0", nm, extra);
    end
  endtask

  initial begin
    int base, obase;
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 8'h55, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b0};

    // Reset state
    repeat (5) @(posedge sys_clk);
    #1;
    chk("reset dut1 outputs", {19'd0, valid1, ovr1, ferr1, perr1, data1}, 32'd0);
    chk("reset dut2 outputs", {20'd0, valid2, ovr2, ferr2, perr2, data2}, 32'd0);
    sys_rst_n = 1'b1;
    idle_bits(1, 2);

    // Table-driven 8N1 frames with out_ready held high
    for (int k = 0; k < 5; k++) begin
      base = vcnt1;
      exp1.push_back({1'b0, vecs[k].exp_data, vecs[k].exp_ferr, 1'b0});
      send(1, {1'b0, vecs[k].data}, 8, 1'b0, 1'b0, vecs[k].stop_bit, 1'b1, 1, -1);
      idle_bits(1, 2);
      drain(1, 4 * BPS, "table word");
      chk("table valid cycles", 32'(vcnt1 - base), 32'd1);
    end

    // Half-bit glitch on idle line is rejected
    base = vcnt1;
    set_rx(1, 1'b0);
    repeat (BPS / 2) begin @(posedge sys_clk); #1; end
    set_rx(1, 1'b1);
    idle_bits(1, 3);
    chk("glitch no word", 32'(vcnt1 - base), 32'd0);
    chk("glitch fsm idle", 32'(dut1.state), 32'(S_IDLE));
    drain(1, 2, "glitch");

    // Overrun: second word dropped while the first is unaccepted
    ready1 = 1'b0;
    obase = ocnt1;
    exp1.push_back({1'b0, 8'h3C, 1'b0, 1'b0});
    send(1, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    send(1, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    idle_bits(1, 1);
    chk("overrun held data", 32'(data1), 32'h3C);
    chk("overrun held valid", 32'(valid1), 32'd1);
    chk("overrun pulses", 32'(ocnt1 - obase), 32'd1);
    ready1 = 1'b1;
    drain(1, 10, "overrun accepted word");
    repeat (2) @(posedge sys_clk);
    #1;
    chk("valid dropped after accept", 32'(valid1), 32'd0);

    // Break: line low for more than a frame gives one framing-error word
    base = vcnt1;
    exp1.push_back({1'b0, 8'h00, 1'b1, 1'b0});
    set_rx(1, 1'b0);
    repeat (12 * BPS) @(posedge sys_clk);
    #1;
    set_rx(1, 1'b1);
    idle_bits(1, 3);
    drain(1, 4 * BPS, "break word");
    chk("break single word", 32'(vcnt1 - base), 32'd1);

    // Single-cycle low spike inside a 1 data bit
    exp1.push_back({1'b0, 8'hFF, 1'b0, 1'b0});
    send(1, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 3);
    idle_bits(1, 2);
    drain(1, 4 * BPS, "spike word");

    // Reset in the middle of a frame while a word is held
    ready1 = 1'b0;
    send(1, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    idle_bits(1, 1);
    hold_bit(1, 1'b0, 1'b0);
    hold_bit(1, 1'b0, 1'b0);
    hold_bit(1, 1'b1, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    chk("reset mid-frame outputs", {19'd0, valid1, ovr1, ferr1, perr1, data1}, 32'd0);
    chk("reset mid-frame fsm", 32'(dut1.state), 32'(S_IDLE));
    exp1.delete(); got1.delete();
    repeat (3) @(posedge sys_clk);
    #1;
    set_rx(1, 1'b1);
    sys_rst_n = 1'b1;
    ready1 = 1'b1;
    idle_bits(1, 2);
    exp1.push_back({1'b0, 8'h96, 1'b0, 1'b0});
    send(1, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    idle_bits(1, 2);
    drain(1, 4 * BPS, "post-reset word");

    // Second instance: 7 data bits, 2 stop bits (even parity when built)
    idle_bits(2, 2);
    exp2.push_back({2'b00, 7'h41, 1'b0, 1'b0});
    send(2, 9'h041, 7, PAR_ON, 1'b0, 1'b1, 1'b1, 2, -1);
    idle_bits(2, 2);
    drain(2, 4 * BPS, "7x2 clean word");

    exp2.push_back({2'b00, 7'h41, 1'b1, 1'b0});
    send(2, 9'h041, 7, PAR_ON, 1'b0, 1'b1, 1'b0, 2, -1);
    idle_bits(2, 2);
    drain(2, 4 * BPS, "second stop low");

    exp2.push_back({2'b00, 7'h2A, 1'b1, 1'b0});
    send(2, 9'h02A, 7, PAR_ON, 1'b1, 1'b0, 1'b1, 2, -1);
    idle_bits(2, 2);
    drain(2, 4 * BPS, "first stop low");

`ifdef UART_RX_PARITY_EN
    exp2.push_back({2'b00, 7'h41, 1'b0, 1'b1});
    send(2, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 2, -1);
    idle_bits(2, 2);
    drain(2, 4 * BPS, "flipped parity");

    exp2.push_back({2'b00, 7'h43, 1'b0, 1'b0});
    send(2, 9'h043, 7, 1'b1, 1'b1, 1'b1, 1'b1, 2, -1);
    idle_bits(2, 2);
    drain(2, 4 * BPS, "odd-weight even parity");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
